// File: rtl/jogador_automatico.sv
// rtl/jogador_automatico.sv - hardware auto-player that drives one round of the memory game
module jogador_automatico #(
  parameter int N_JOGADAS = 16,
  parameter int T_INICIAR = 5,
  parameter int T_HOLD    = 10,
  parameter int T_GAP     = 10,
  parameter int T_TIMEOUT = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       erro_en,
  input  logic [3:0] erro_idx,
  input  logic       acertou,
  input  logic       errou,
  input  logic       pronto,
  output logic       iniciar,
  output logic [3:0] chaves,
  output logic       fim,
  output logic       sucesso,
  output logic       timeout,
  output logic [3:0] db_estado,
  output logic [3:0] db_idx
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    PULSO     = 4'd1,
    ESPERA    = 4'd2,
    APRESENTA = 4'd3,
    LIBERA    = 4'd4,
    AGUARDA   = 4'd5,
    FIM       = 4'd6
  } estado_t;

  // Each timed state lasts exactly T cycles: the timer restarts at 0 on entry.
  localparam logic [7:0] LIM_INI  = 8'(T_INICIAR - 1);
  localparam logic [7:0] LIM_HOLD = 8'(T_HOLD - 1);
  localparam logic [7:0] LIM_GAP  = 8'(T_GAP - 1);
  localparam logic [7:0] LIM_TO   = 8'(T_TIMEOUT - 1);
  localparam logic [3:0] LIM_IDX  = 4'(N_JOGADAS - 1);

  estado_t    state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [3:0] idx_q, idx_d;
  logic       err_en_q, err_en_d;
  logic [3:0] err_idx_q, err_idx_d;
  logic       iniciar_q, iniciar_d;
  logic [3:0] chaves_q, chaves_d;
  logic       fim_q, fim_d;
  logic       sucesso_q, sucesso_d;
  logic       timeout_q, timeout_d;

  // Expected one-hot for jogada idx; the wrong value is that rotated by two.
  // idx never exceeds N_JOGADAS-1, so an out-of-range erro_idx never matches.
  function automatic logic [3:0] jogada_valor(input logic [3:0] idx, input logic en,
                                              input logic [3:0] eidx);
    logic [3:0] esperado;
    esperado = 4'b0001 << idx[1:0];
    if (en && (idx == eidx)) return {esperado[1:0], esperado[3:2]};
    return esperado;
  endfunction

  // Next-state, counters and next values of the registered outputs.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_en_d  = err_en_q;
    err_idx_d = err_idx_q;
    fim_d     = fim_q;
    sucesso_d = sucesso_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = PULSO;
          fim_d     = 1'b0;
          sucesso_d = 1'b0;
          timeout_d = 1'b0;
          idx_d     = 4'd0;
          err_en_d  = erro_en;
          err_idx_d = erro_idx;
        end
      end
      PULSO:  if (timer_q == LIM_INI) state_d = ESPERA;
      ESPERA: if (timer_q == LIM_GAP) state_d = APRESENTA;
      APRESENTA: begin
        if (pronto) begin
          state_d   = FIM;
          sucesso_d = acertou & ~errou;
          timeout_d = 1'b0;
        end else if (timer_q == LIM_HOLD) begin
          state_d = LIBERA;
        end
      end
      LIBERA: begin
        if (pronto) begin
          state_d   = FIM;
          sucesso_d = acertou & ~errou;
          timeout_d = 1'b0;
        end else if (timer_q == LIM_GAP) begin
          if (idx_q == LIM_IDX) begin
            state_d = AGUARDA;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = APRESENTA;
          end
        end
      end
      AGUARDA: begin
        if (pronto) begin
          state_d   = FIM;
          sucesso_d = acertou & ~errou;
          timeout_d = 1'b0;
        end else if (timer_q == LIM_TO) begin
          state_d   = FIM;
          sucesso_d = 1'b0;
          timeout_d = 1'b1;
        end
      end
      FIM:     if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == FIM) fim_d = 1'b1;
    timer_d   = (state_d != state_q) ? 8'd0 : timer_q + 8'd1;
    iniciar_d = (state_d == PULSO);
    chaves_d  = (state_d == APRESENTA) ? jogada_valor(idx_d, err_en_d, err_idx_d) : 4'd0;
  end

  // State and output registers; outputs never see inputs combinationally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      timer_q   <= 8'd0;
      idx_q     <= 4'd0;
      err_en_q  <= 1'b0;
      err_idx_q <= 4'd0;
      iniciar_q <= 1'b0;
      chaves_q  <= 4'd0;
      fim_q     <= 1'b0;
      sucesso_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      err_en_q  <= err_en_d;
      err_idx_q <= err_idx_d;
      iniciar_q <= iniciar_d;
      chaves_q  <= chaves_d;
      fim_q     <= fim_d;
      sucesso_q <= sucesso_d;
      timeout_q <= timeout_d;
    end
  end

  assign iniciar   = iniciar_q;
  assign chaves    = chaves_q;
  assign fim       = fim_q;
  assign sucesso   = sucesso_q;
  assign timeout   = timeout_q;
  assign db_estado = state_q;
  assign db_idx    = idx_q;

endmodule

// File: tb/tb_jogador_automatico.sv
// tb/tb_jogador_automatico.sv - auto-player checked against a cycle-count reference and a game model
module tb_jogador_automatico;

  localparam int N  = 4;
  localparam int TO = 255;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       erro_en = 1'b0;
  logic [3:0] erro_idx = 4'd0;
  logic       acertou = 1'b0;
  logic       errou = 1'b0;
  logic       pronto = 1'b0;
  logic       iniciar;
  logic [3:0] chaves;
  logic       fim, sucesso, timeout;
  logic [3:0] db_estado, db_idx;

  int ntests = 0;
  int nfail  = 0;

  // game model state
  int   g_pos = 0;
  bit   g_seen_ini = 0;
  logic [3:0] g_prev = 4'd0;

  jogador_automatico #(.N_JOGADAS(N), .T_INICIAR(5), .T_HOLD(10), .T_GAP(10), .T_TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .start(start), .erro_en(erro_en), .erro_idx(erro_idx),
    .acertou(acertou), .errou(errou), .pronto(pronto), .iniciar(iniciar), .chaves(chaves),
    .fim(fim), .sucesso(sucesso), .timeout(timeout), .db_estado(db_estado), .db_idx(db_idx)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected chaves at cycle k after the start edge, from the round timeline:
  // 5 cycles iniciar, 10 gap, then per jogada 10 cycles value + 10 gap.
  function automatic logic [3:0] exp_chaves(input int k, input int e);
    int m, j;
    logic [3:0] v;
    if (k < 15) return 4'd0;
    m = k - 15;
    j = m / 20;
    if (j >= N || (m % 20) >= 10) return 4'd0;
    v = 4'(1 << (j % 4));
    if (j == e) v = {v[1:0], v[3:2]};
    return v;
  endfunction

  // Game reacts to the rising chaves; pronto stays until iniciar has pulsed.
  task automatic game_step(input bit stuck, input bit both);
    if (iniciar) g_seen_ini = 1;
    else if (g_seen_ini) begin
      g_seen_ini = 0; g_pos = 0; pronto = 0; acertou = 0; errou = 0;
    end
    if (g_prev == 4'd0 && chaves != 4'd0 && !stuck) begin
      if (chaves != 4'(1 << (g_pos % 4))) begin
        errou = 1; pronto = 1;
      end else begin
        g_pos++;
        if (g_pos == N) begin
          acertou = 1; pronto = 1;
          if (both) errou = 1;
        end
      end
    end
    g_prev = chaves;
  endtask

  task automatic run(input bit en, input logic [3:0] eidx, input bit stuck, input bit both,
                     input bit rnd_start);
    int e, kend, exp_idx;
    bit exp_suc, exp_to;
    e = (en && eidx < N) ? int'(eidx) : -1;
    if (stuck) begin
      kend = 15 + 20 * N + TO; exp_suc = 0; exp_to = 1; exp_idx = N - 1;
    end else if (e >= 0) begin
      kend = 16 + 20 * e; exp_suc = 0; exp_to = 0; exp_idx = e;
    end else begin
      kend = 16 + 20 * (N - 1); exp_suc = !both; exp_to = 0; exp_idx = N - 1;
    end
    g_pos = 0; g_seen_ini = 0; g_prev = 4'd0;
    erro_en = en; erro_idx = eidx; start = 1;
    for (int k = 0; k <= kend; k++) begin
      @(negedge clock);
      if (k < kend) begin
        chk($sformatf("trace k=%0d", k), {fim, iniciar, chaves},
            {1'b0, (k < 5) ? 1'b1 : 1'b0, exp_chaves(k, e)});
        game_step(stuck, both);
        if (rnd_start) begin
          start = 1'($urandom_range(0, 1));
          erro_en = 1'($urandom_range(0, 1));
          erro_idx = 4'($urandom_range(0, 15));
        end
      end
    end
    chk("fim_estado", db_estado, 4'd6);
    chk("fim_out", {fim, iniciar, chaves}, {1'b1, 1'b0, 4'd0});
    chk("sucesso", sucesso, exp_suc);
    chk("timeout", timeout, exp_to);
    chk("db_idx", db_idx, exp_idx[3:0]);
    start = 1;
    for (int h = 0; h < 3; h++) begin
      @(negedge clock);
      chk("hold_fim", {db_estado, fim}, {4'd6, 1'b1});
    end
    start = 0;
    @(negedge clock);
    chk("idle_held", {db_estado, fim, sucesso, timeout, chaves},
        {4'd0, 1'b1, exp_suc, exp_to, 4'd0});
  endtask

  initial begin
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    reset = 0;
    chk("reset", {iniciar, chaves, fim, sucesso, timeout, db_estado, db_idx}, 15'd0);

    run(0, 4'd0, 0, 0, 0);   // clean round
    run(1, 4'd3, 0, 0, 0);   // last jogada wrong
    run(1, 4'd0, 0, 0, 0);   // first jogada wrong
    run(1, 4'd9, 0, 0, 0);   // out-of-range index: no error
    run(0, 4'd0, 0, 1, 0);   // acertou and errou together
    run(0, 4'd0, 1, 0, 0);   // game stuck -> timeout

    // reset in the middle of APRESENTA with start held high
    start = 1; erro_en = 0;
    for (int k = 0; k < 18; k++) @(negedge clock);
    chk("pre_reset_chaves", chaves, 4'b0001);
    #2 reset = 1;
    #1 chk("reset_mid", {chaves, iniciar, db_estado}, 9'd0);
    @(negedge clock);
    reset = 0;
    pronto = 0; acertou = 0; errou = 0;
    run(0, 4'd0, 0, 0, 0);

    for (int r = 0; r < 8; r++)
      run(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)), 1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
